// File: rtl/rom_uart_streamer.sv
// Streams ROM words 0..last_addr to a UART TX byte interface, MSB first,
// over a valid/ready handshake.
module rom_uart_streamer #(
    parameter int unsigned W      = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [W-1:0]      rom_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned NBYTES = W / 8;
    localparam int unsigned CntW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StSend, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [W-1:0]      shift_q, shift_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            last_q  <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    last_d  = last_addr;
                    addr_d  = '0;
                    state_d = StLoad;
                end
            end
            // ROM address was registered last cycle, so rom_data is settled here.
            StLoad: begin
                shift_d = rom_data;
                cnt_d   = '0;
                state_d = StSend;
            end
            StSend: begin
                if (tx_ready) begin
                    if (cnt_q != CntW'(NBYTES - 1)) begin
                        shift_d = shift_q << 8;
                        cnt_d   = cnt_q + 1'b1;
                    end else if (addr_q != last_q) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = StLoad;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode straight from state so reset drops tx_valid without a clock.
    assign rom_address = addr_q;
    assign tx_data     = shift_q[W-1 -: 8];
    assign tx_valid    = (state_q == StSend);
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);

endmodule

// File: tb/tb_rom_uart_streamer.sv
// Randomized self-checking bench for rom_uart_streamer against a byte-queue
// reference built from the ROM contents and the requested last address.
module tb_rom_uart_streamer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  last_addr;
    logic [9:0]  rom_address;
    logic [31:0] rom_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        done;

    logic [31:0] rom [1024];
    assign rom_data = rom[rom_address];

    rom_uart_streamer #(.W(32), .ADDR_W(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .last_addr  (last_addr),
        .rom_address(rom_address),
        .rom_data   (rom_data),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;
    int done_cnt = 0;
    int xfer_cnt = 0;
    int ready_mode = 0;
    bit mon_en = 1'b0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic [7:0] exp_q[$];
    int         exp_addr_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: every word 0..last, bytes most significant first.
    task automatic build_expect(input int last);
        for (int a = 0; a <= last; a++) begin
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(8'((rom[a] >> (8 * (3 - b))) & 32'hFF));
                exp_addr_q.push_back(a);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scores every accepted byte and the hold-while-stalled rule.
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en || !rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 32'(tx_valid), 1);
                    check("hold_data", 32'(tx_data), 32'(prev_data));
                end
                if (done) done_cnt++;
                if (tx_valid && tx_ready) begin
                    xfer_cnt++;
                    check("byte_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        check("byte", 32'(tx_data), 32'(exp_q.pop_front()));
                        check("byte_addr", 32'(rom_address), 32'(exp_addr_q.pop_front()));
                    end
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
            end
        end
    end

    task automatic run_dump(input int last, input int mode, input bit disturb);
        int base;
        bit got_done;
        build_expect(last);
        ready_mode = mode;
        base = done_cnt;
        @(negedge clk);
        start = 1'b1;
        last_addr = 10'(last);
        @(posedge clk);
        #1 start = 1'b0;
        got_done = 1'b0;
        for (int c = 0; c < 6000 && !got_done; c++) begin
            @(negedge clk);
            if (disturb && c == 7) begin
                start = 1'b1;
                last_addr = 10'd0;
            end
            if (disturb && c == 8) start = 1'b0;
            if (done) got_done = 1'b1;
        end
        check("done_seen", 32'(got_done), 1);
        check("leftover_bytes", 32'(exp_q.size()), 0);
        if (disturb) start = 1'b1;  // lands in the DONE cycle, must be ignored
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("busy_after", 32'(busy), 0);
        check("done_single", 32'(done), 0);
        check("addr_hold", 32'(rom_address), 32'(last));
        repeat (2) @(negedge clk);
        check("idle_stays", 32'(busy), 0);
        check("done_count", 32'(done_cnt - base), 1);
        ready_mode = 0;
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        start = 1'b0;
        last_addr = '0;
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(tx_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_addr", 32'(rom_address), 0);
        check("rst_data", 32'(tx_data), 0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // 1: cycle-exact single word
        rom[0] = 32'h3F800000;
        build_expect(0);
        @(negedge clk);
        start = 1'b1;
        last_addr = 10'd0;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("t1_load_busy", 32'(busy), 1);
        check("t1_load_valid", 32'(tx_valid), 0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            check("t1_valid", 32'(tx_valid), 1);
            check("t1_data", 32'(tx_data), 32'((32'h3F800000 >> (8 * (3 - b))) & 32'hFF));
        end
        @(negedge clk);
        check("t1_done", 32'(done), 1);
        check("t1_done_valid", 32'(tx_valid), 0);
        @(negedge clk);
        check("t1_busy_low", 32'(busy), 0);
        check("t1_done_low", 32'(done), 0);

        // 2 and 3: counting pattern, steady then random ready
        for (int i = 0; i < 8; i++) rom[i] = 32'(i);
        run_dump(3, 0, 1'b0);
        run_dump(7, 1, 1'b0);

        // 5: restart attempts and last_addr change mid-dump
        for (int i = 0; i < 8; i++) rom[i] = $urandom;
        run_dump(5, 1, 1'b1);

        // 6: reset in the middle of word 1
        for (int i = 0; i < 4; i++) rom[i] = 32'(i);
        build_expect(3);
        seen = xfer_cnt;
        @(negedge clk);
        start = 1'b1;
        last_addr = 10'd3;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < 100 && (xfer_cnt - seen) < 5; c++) @(negedge clk);
        check("t6_reached", 32'(xfer_cnt - seen), 5);
        #2;
        rst_n = 1'b0;
        mon_en = 1'b0;
        #1;
        check("t6_valid", 32'(tx_valid), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_addr", 32'(rom_address), 0);
        check("t6_data", 32'(tx_data), 0);
        exp_q.delete();
        exp_addr_q.delete();
        repeat (2) @(negedge clk);
        check("t6_still_idle", 32'(busy), 0);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        run_dump(3, 0, 1'b0);

        // 4: full ROM, no wrap
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        run_dump(1023, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
